sms_power_sbox_seq: RTL and testbench



---
 rtl/sms_power_sbox_seq_pkg.sv | 27 ++
 rtl/sms_power_sbox_seq_if.sv | 23 ++
 rtl/sms_power_sbox_seq_mul.sv | 32 +++
 rtl/sms_power_sbox_seq.sv | 102 ++++++++++
 tb/tb_sms_power_sbox_seq.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sms_power_sbox_seq_pkg.sv
// Shared types and constants for the power-map S-box engine.
// Holds the FSM state enum, the N=6 defaults and a GF(2^n) multiply reference.
package sms_gf_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [6:0] SMS_N6_POLY = 7'h43;
  localparam logic [5:0] SMS_N6_LIN  = 6'h14;

  // Horner-style shift-and-add: a*b mod poly, n-bit field, n <= 16.
  function automatic logic [15:0] gf_mul_red(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [16:0] poly,
    input int          n
  );
    logic [16:0] r;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[n]) r = r ^ poly;
      if (b[i]) r = r ^ {1'b0, a};
    end
    return r[15:0];
  endfunction

endpackage

// File: rtl/sms_power_sbox_seq_if.sv
// Valid/ready bus of the power-map S-box engine.
// master: producer/consumer side; slave: the engine (x_in/e_in in, y_out out).
interface sms_power_sbox_seq_if #(
  parameter int N = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x_in;
  logic [N-1:0] e_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y_out;

  modport master (
    output in_valid, x_in, e_in, out_ready,
    input  in_ready, out_valid, y_out
  );

  modport slave (
    input  in_valid, x_in, e_in, out_ready,
    output in_ready, out_valid, y_out
  );
endinterface

// File: rtl/sms_power_sbox_seq_mul.sv
// gf2n_mul: combinational a*b mod POLY over GF(2^N), polynomial basis.
// Ports: a, b (N-bit operands), p (N-bit reduced product).
module gf2n_mul #(
  parameter int         N    = 6,
  parameter logic [N:0] POLY = 7'h43
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);
  localparam int W = 2 * N - 1;

  logic [W-1:0] prod;
  logic [W-1:0] aw;
  logic [W-1:0] pw;

  // Full carry-less product, then fold the high bits down from the top.
  always_comb begin
    aw = '0;
    aw[N-1:0] = a;
    pw = '0;
    pw[N:0] = POLY;
    prod = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) prod = prod ^ (aw << i);
    end
    for (int j = W - 1; j >= N; j--) begin
      if (prod[j]) prod = prod ^ (pw << (j - N));
    end
    p = prod[N-1:0];
  end
endmodule

// File: rtl/sms_power_sbox_seq.sv
// Iterative y = x^E ^ {N{parity(x & LIN_MASK)}} over GF(2^N), MSB-first.
// Ports: clk, rst (async high), bus (slave handshake bundle), busy.
module sms_power_sbox_seq
  import sms_gf_pkg::*;
#(
  parameter int           N        = 6,
  parameter logic [N:0]   POLY     = SMS_N6_POLY,
  parameter logic [N-1:0] LIN_MASK = SMS_N6_LIN
) (
  input  logic                   clk,
  input  logic                   rst,
  sms_power_sbox_seq_if.slave    bus,
  output logic                   busy
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t        state;
  state_t        nxt;
  logic [N-1:0]  x_r;
  logic [N-1:0]  e_r;
  logic [N-1:0]  acc;
  logic [N-1:0]  y_r;
  logic [N-1:0]  sq;
  logic [N-1:0]  sqx;
  logic [N-1:0]  acc_nxt;
  logic [KW-1:0] k;
  logic          t_r;
  logic          ov_r;
  logic          last;

  gf2n_mul #(.N(N), .POLY(POLY)) u_sq (
    .a (acc),
    .b (acc),
    .p (sq)
  );

  gf2n_mul #(.N(N), .POLY(POLY)) u_mx (
    .a (sq),
    .b (x_r),
    .p (sqx)
  );

  assign acc_nxt = e_r[k] ? sqx : sq;
  assign last    = (k == '0);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r  <= '0;
      e_r  <= '0;
      acc  <= '0;
      y_r  <= '0;
      k    <= '0;
      t_r  <= 1'b0;
      ov_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_r <= bus.x_in;
            e_r <= bus.e_in;
            acc <= N'(1);
            k   <= KW'(N - 1);
            t_r <= ^(bus.x_in & LIN_MASK);
          end
        end
        RUN: begin
          acc <= acc_nxt;
          k   <= k - KW'(1);
          // Result is registered as RUN retires so y_out/out_valid need no decode.
          if (last) begin
            y_r  <= acc_nxt ^ {N{t_r}};
            ov_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) ov_r <= 1'b0;
        end
        default: ov_r <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = ov_r;
  assign bus.y_out     = y_r;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_sms_power_sbox_seq.sv
// Directed and sweep bench for sms_power_sbox_seq at N=6 and N=4.
// Drives and samples on the falling edge.
module tb_sms_power_sbox_seq;
  import sms_gf_pkg::*;

  typedef struct {
    logic [5:0] x;
    logic [5:0] e;
    logic [5:0] y;
  } vec_t;

  logic clk;
  logic rst;
  logic busy6;
  logic busy4;
  int   n_cmp;
  int   n_bad;

  sms_power_sbox_seq_if #(.N(6)) b6 ();
  sms_power_sbox_seq_if #(.N(4)) b4 ();

  sms_power_sbox_seq #(
    .N(6), .POLY(7'h43), .LIN_MASK(6'h14)
  ) dut6 (
    .clk  (clk),
    .rst  (rst),
    .bus  (b6),
    .busy (busy6)
  );

  sms_power_sbox_seq #(
    .N(4), .POLY(5'h13), .LIN_MASK(4'h5)
  ) dut4 (
    .clk  (clk),
    .rst  (rst),
    .bus  (b4),
    .busy (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Bench model: E repeated multiplications, then the parity mask.
  function automatic logic [15:0] model(input logic [15:0] x,
    input int e, input logic [16:0] poly, input logic [15:0] lin,
    input int n);
    logic [15:0] r;
    logic [15:0] m;
    r = 16'd1;
    for (int i = 0; i < e; i++) r = gf_mul_red(r, x, poly, n);
    m = (^(x & lin)) ? 16'((1 << n) - 1) : 16'd0;
    return r ^ m;
  endfunction

  task automatic txn6(input logic [5:0] x, input logic [5:0] e,
    input int stall, output logic [5:0] y, output int edges);
    int w;
    w = 0;
    edges = 0;
    while (!b6.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!b6.in_ready) chk("in_ready_wait6", 32'(b6.in_ready), 1);
    b6.in_valid = 1'b1;
    b6.x_in = x;
    b6.e_in = e;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    b6.in_valid = 1'b0;
    while (!b6.out_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!b6.out_valid) chk("out_valid_wait6", 32'(b6.out_valid), 1);
    y = b6.y_out;
    repeat (stall) @(negedge clk);
    b6.out_ready = 1'b1;
    @(negedge clk);
    b6.out_ready = 1'b0;
  endtask

  task automatic txn4(input logic [3:0] x, input logic [3:0] e,
    input int stall, output logic [3:0] y);
    int w;
    int edges;
    w = 0;
    while (!b4.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!b4.in_ready) chk("in_ready_wait4", 32'(b4.in_ready), 1);
    b4.in_valid = 1'b1;
    b4.x_in = x;
    b4.e_in = e;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    b4.in_valid = 1'b0;
    while (!b4.out_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!b4.out_valid) chk("out_valid_wait4", 32'(b4.out_valid), 1);
    chk("latency4", 32'(edges), 5);
    y = b4.y_out;
    repeat (stall) @(negedge clk);
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;
  endtask

  initial begin
    vec_t       tv[6];
    logic [5:0] y6;
    logic [3:0] y4;
    int         ed;
    int         e6[5];
    int         e4[5];
    int         w;

    n_cmp = 0;
    n_bad = 0;
    tv[0] = '{x: 6'h02, e: 6'd19, y: 6'h1E};
    tv[1] = '{x: 6'h04, e: 6'd1,  y: 6'h3B};
    tv[2] = '{x: 6'h01, e: 6'd19, y: 6'h01};
    tv[3] = '{x: 6'h00, e: 6'd0,  y: 6'h01};
    tv[4] = '{x: 6'h00, e: 6'd19, y: 6'h00};
    tv[5] = '{x: 6'h02, e: 6'd63, y: 6'h01};
    e6 = '{0, 1, 5, 19, 62};
    e4 = '{0, 1, 5, 13, 15};

    rst = 1'b1;
    b6.in_valid = 1'b0; b6.x_in = '0; b6.e_in = '0; b6.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.x_in = '0; b4.e_in = '0; b4.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(b6.in_ready), 1);
    chk("rst_out_valid", 32'(b6.out_valid), 0);
    chk("rst_busy", 32'(busy6), 0);
    chk("rst_y_out", 32'(b6.y_out), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      txn6(tv[i].x, tv[i].e, 0, y6, ed);
      chk($sformatf("vec%0d_y", i), 32'(y6), 32'(tv[i].y));
      chk($sformatf("vec%0d_lat", i), 32'(ed), 7);
    end

    // Backpressure: result held, inputs ignored while DONE stalls.
    b6.in_valid = 1'b1; b6.x_in = 6'h04; b6.e_in = 6'd1;
    @(posedge clk);
    @(negedge clk);
    b6.in_valid = 1'b0;
    w = 0;
    while (!b6.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("bp_out_valid", 32'(b6.out_valid), 1);
    for (int c = 0; c < 10; c++) begin
      b6.in_valid = 1'b1; b6.x_in = 6'h02; b6.e_in = 6'd19;
      @(negedge clk);
      chk("bp_y_hold", 32'(b6.y_out), 32'h3B);
      chk("bp_in_ready", 32'(b6.in_ready), 0);
      chk("bp_valid_hold", 32'(b6.out_valid), 1);
    end
    b6.in_valid = 1'b0;
    b6.out_ready = 1'b1;
    @(negedge clk);
    b6.out_ready = 1'b0;
    chk("bp_rel_valid", 32'(b6.out_valid), 0);
    chk("bp_rel_idle", 32'(b6.in_ready), 1);
    @(negedge clk);
    chk("bp_no_queue", 32'(busy6), 0);

    // Reset in the third RUN cycle discards the transaction.
    b6.in_valid = 1'b1; b6.x_in = 6'h02; b6.e_in = 6'd19;
    @(posedge clk);
    @(negedge clk);
    b6.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(busy6), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(b6.out_valid), 0);
    chk("mid_rst_busy", 32'(busy6), 0);
    chk("mid_rst_y", 32'(b6.y_out), 0);
    chk("mid_rst_ready", 32'(b6.in_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    txn6(6'h02, 6'd19, 2, y6, ed);
    chk("post_rst_y", 32'(y6), 32'h1E);
    chk("post_rst_lat", 32'(ed), 7);

    for (int x = 0; x < 64; x++) begin
      for (int j = 0; j < 5; j++) begin
        txn6(6'(x), 6'(e6[j]), int'($urandom_range(0, 3)), y6, ed);
        chk($sformatf("sw6_x%0d_e%0d", x, e6[j]), 32'(y6),
            32'(model(16'(x), e6[j], 17'h43, 16'h14, 6)));
      end
    end

    for (int x = 0; x < 16; x++) begin
      for (int j = 0; j < 5; j++) begin
        txn4(4'(x), 4'(e4[j]), int'($urandom_range(0, 3)), y4);
        chk($sformatf("sw4_x%0d_e%0d", x, e4[j]), 32'(y4),
            32'(model(16'(x), e4[j], 17'h13, 16'h5, 4)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
